// File: rtl/tcp_handshake_scheduler.sv
// Round-robin owner of a single server-side handshake endpoint: SYN, wait for
// SYN_ACK with bounded retries, ACK, then hold the connection until released.
module tcp_handshake_scheduler #(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clock_i,
    input  logic                 rst_ni,
    input  logic [N_CLIENTS-1:0] req_i,
    input  logic                 rcv_syn_ack_i,
    output logic                 send_syn_o,
    output logic                 send_ack_o,
    output logic [N_CLIENTS-1:0] grant_o,
    output logic                 established_o,
    output logic [N_CLIENTS-1:0] fail_o,
    output logic                 busy_o,
    output logic [7:0]           conn_count_o
);
    localparam int PW = $clog2(N_CLIENTS);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SYN_SENT, ACK_SEND, ESTABLISHED} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [3:0]           retry_q, retry_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [N_CLIENTS-1:0] fail_q, fail_d;
    logic                 send_syn_q, send_syn_d;
    logic                 send_ack_q, send_ack_d;
    logic                 established_q, busy_q;
    logic [7:0]           conn_q, conn_d;

    logic [PW:0]          cand;
    logic [PW-1:0]        sel_idx;
    logic                 sel_found;

    // First requester after rr_ptr, wrapping at N_CLIENTS (need not be a power of two).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_CLIENTS; i++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_CLIENTS)) cand = cand - (PW+1)'(N_CLIENTS);
            if (!sel_found && req_i[cand[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        grant_d    = grant_q;
        conn_d     = conn_q;
        send_syn_d = 1'b0;
        send_ack_d = 1'b0;
        fail_d     = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d    = SYN_SENT;
                    owner_d    = sel_idx;
                    grant_d    = N_CLIENTS'(1) << sel_idx;
                    send_syn_d = 1'b1;
                    timer_d    = '0;
                    retry_d    = '0;
                end
            end
            SYN_SENT: begin
                timer_d = timer_q + TW'(1);
                // Release by the owner beats both SYN_ACK and timeout.
                if (!req_i[owner_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = owner_q;
                end else if (rcv_syn_ack_i) begin
                    state_d = ACK_SEND;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    if (retry_q < 4'(MAX_RETRY)) begin
                        retry_d    = retry_q + 4'd1;
                        timer_d    = '0;
                        send_syn_d = 1'b1;
                    end else begin
                        fail_d   = grant_q;
                        grant_d  = '0;
                        rr_ptr_d = owner_q;
                        state_d  = IDLE;
                    end
                end
            end
            ACK_SEND: begin
                send_ack_d = 1'b1;
                if (conn_q != 8'hFF) conn_d = conn_q + 8'd1;
                state_d = ESTABLISHED;
            end
            ESTABLISHED: begin
                if (!req_i[owner_q]) begin
                    grant_d  = '0;
                    rr_ptr_d = owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= PW'(N_CLIENTS - 1);
            timer_q       <= '0;
            retry_q       <= '0;
            grant_q       <= '0;
            fail_q        <= '0;
            send_syn_q    <= 1'b0;
            send_ack_q    <= 1'b0;
            established_q <= 1'b0;
            busy_q        <= 1'b0;
            conn_q        <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            grant_q       <= grant_d;
            fail_q        <= fail_d;
            send_syn_q    <= send_syn_d;
            send_ack_q    <= send_ack_d;
            established_q <= (state_d == ESTABLISHED);
            busy_q        <= (state_d != IDLE);
            conn_q        <= conn_d;
        end
    end

    assign send_syn_o    = send_syn_q;
    assign send_ack_o    = send_ack_q;
    assign grant_o       = grant_q;
    assign established_o = established_q;
    assign fail_o        = fail_q;
    assign busy_o        = busy_q;
    assign conn_count_o  = conn_q;
endmodule

// File: tb/tb_tcp_handshake_scheduler.sv
// Bench for tcp_handshake_scheduler: directed test-plan scenarios plus random
// traffic, checked cycle by cycle against a timestamp-based session model.
module tb_tcp_handshake_scheduler;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int MR = 3;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         syn;
        logic         ack;
        logic         est;
        logic [N-1:0] fail;
        logic         busy;
        logic [7:0]   conn;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         sack;
    logic         send_syn, send_ack, est, busy;
    logic [N-1:0] grant, fail;
    logic [7:0]   conn;

    int tests = 0;
    int fails = 0;
    int syn_cnt = 0, ack_cnt = 0, fail_cnt = 0;
    obs_t exp_q[$];

    tcp_handshake_scheduler #(.N_CLIENTS(N), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clock_i(clk), .rst_ni(rst_n), .req_i(req), .rcv_syn_ack_i(sack),
        .send_syn_o(send_syn), .send_ack_o(send_ack), .grant_o(grant),
        .established_o(est), .fail_o(fail), .busy_o(busy), .conn_count_o(conn)
    );

    always #5 clk = ~clk;

    // Reference: a session is an owner index plus the time of its latest SYN.
    int m_owner, m_rr, m_syn_t, m_nsyn, m_conn, t, c;
    bit m_est, m_ackpend, m_found;
    always @(posedge clk) begin : model
        obs_t e;
        t++;
        e = '0;
        if (!rst_n) begin
            m_owner = -1; m_rr = N - 1; m_est = 0; m_ackpend = 0; m_conn = 0;
        end else if (m_owner < 0) begin
            m_found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (!m_found && req[c]) begin m_found = 1; m_owner = c; end
            end
            if (m_found) begin m_syn_t = t; m_nsyn = 1; e.syn = 1; end
        end else if (m_ackpend) begin
            m_ackpend = 0; m_est = 1; e.ack = 1;
            if (m_conn < 255) m_conn++;
        end else if (m_est) begin
            if (!req[m_owner]) begin m_rr = m_owner; m_owner = -1; m_est = 0; end
        end else begin
            if (!req[m_owner]) begin
                m_rr = m_owner; m_owner = -1;
            end else if (sack) begin
                m_ackpend = 1;
            end else if (t - m_syn_t == TO) begin
                if (m_nsyn <= MR) begin m_nsyn++; m_syn_t = t; e.syn = 1; end
                else begin e.fail = N'(1) << m_owner; m_rr = m_owner; m_owner = -1; end
            end
        end
        e.grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.est   = m_est;
        e.busy  = (m_owner >= 0);
        e.conn  = 8'(m_conn);
        exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        obs_t e, g;
        #1;
        g.grant = grant; g.syn = send_syn; g.ack = send_ack; g.est = est;
        g.fail = fail; g.busy = busy; g.conn = conn;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty at t=%0d", t);
        end else begin
            e = exp_q.pop_front();
            if (g !== e || !$onehot0(grant)) begin
                fails++;
                $display("FAIL cycle t=%0d: got grant=%b syn=%b ack=%b est=%b fail=%b busy=%b conn=%0d, expected grant=%b syn=%b ack=%b est=%b fail=%b busy=%b conn=%0d",
                         t, g.grant, g.syn, g.ack, g.est, g.fail, g.busy, g.conn,
                         e.grant, e.syn, e.ack, e.est, e.fail, e.busy, e.conn);
            end
        end
        if (send_syn) syn_cnt++;
        if (send_ack) ack_cnt++;
        if (fail != 0) fail_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_syn();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (send_syn) seen = 1;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL wait_syn: no send_syn within 200 cycles");
        end
    endtask

    // One quick session on the only requesting client, then release.
    task automatic quick_session(input logic [N-1:0] r);
        req = r; wait_syn();
        tick(1); sack = 1; tick(1); sack = 0; tick(2);
        req = '0; tick(2);
    endtask

    int s0, a0, f0, div;
    bit got_fail;
    initial begin
        rst_n = 1; req = '0; sack = 0;
        #1 rst_n = 0;
        #1 chk("reset_outputs", {grant, send_syn, send_ack, est, fail, busy, conn}, 0);
        tick(3); rst_n = 1;

        // Basic handshake
        s0 = syn_cnt; req = 4'b0001; wait_syn();
        chk("basic_grant", grant, 4'b0001);
        tick(3); sack = 1; tick(1); sack = 0; tick(2);
        chk("basic_est", est, 1); chk("basic_conn", conn, 1);
        chk("basic_syn_count", syn_cnt - s0, 1);
        req = '0; tick(1);
        chk("basic_release", {grant, est}, 0);
        tick(2);

        // Round-robin, rr pointer sits at client 0 after the basic session
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_syn();
            chk("rr_grant", grant, 32'(4'b0001 << ((1 + k) % 4)));
            tick(1); sack = 1; tick(1); sack = 0; tick(3);
            req[(1 + k) % 4] = 0; tick(1); req = 4'b1111;
        end
        req = '0; tick(3);
        chk("rr_conn", conn, 6);

        // Timeout with retries exhausted
        s0 = syn_cnt; f0 = fail_cnt; got_fail = 0; req = 4'b0001;
        for (int i = 0; i < 150 && !got_fail; i++) begin
            @(negedge clk);
            if (fail != 0) begin got_fail = 1; req = '0; end
        end
        chk("timeout_fail_seen", got_fail, 1);
        chk("timeout_syn_count", syn_cnt - s0, 4);
        chk("timeout_fail_count", fail_cnt - f0, 1);
        tick(1);
        chk("timeout_grant_clear", grant, 0); chk("timeout_conn", conn, 6);
        tick(2);

        // SYN_ACK in the same cycle as the second timeout
        s0 = syn_cnt; a0 = ack_cnt; req = 4'b0010;
        wait_syn(); wait_syn();
        tick(15); sack = 1; tick(1); sack = 0; tick(3);
        chk("late_est", est, 1); chk("late_syn_count", syn_cnt - s0, 2);
        chk("late_ack_count", ack_cnt - a0, 1); chk("late_conn", conn, 7);
        req = '0; tick(3);

        // Abort in SYN_SENT, then spurious SYN_ACK while idle
        a0 = ack_cnt; f0 = fail_cnt; req = 4'b0100; wait_syn();
        tick(4); req = '0; tick(3);
        sack = 1; tick(1); sack = 0; tick(3);
        chk("abort_no_ack", ack_cnt - a0, 0); chk("abort_no_fail", fail_cnt - f0, 0);
        chk("abort_idle", {busy, grant}, 0);

        // Asynchronous reset while established
        req = 4'b1000; wait_syn();
        tick(1); sack = 1; tick(1); sack = 0; tick(3);
        chk("pre_reset_est", est, 1);
        #2 rst_n = 0;
        #1 chk("async_reset_outputs", {grant, send_syn, send_ack, est, fail, busy, conn}, 0);
        @(negedge clk); req = 4'b0100; rst_n = 1;
        wait_syn();
        chk("post_reset_grant", grant, 4'b0100);
        tick(1); sack = 1; tick(1); sack = 0; tick(3);
        chk("post_reset_conn", conn, 1);
        req = '0; tick(3);

        // Random traffic, SYN_ACK density varying per block
        for (int blk = 0; blk < 8; blk++) begin
            div = (blk % 3 == 0) ? 3 : (blk % 3 == 1) ? 30 : 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                for (int b = 0; b < N; b++) begin
                    if (req[b] && $urandom_range(15) == 0) req[b] = 0;
                    else if (!req[b] && $urandom_range(5) == 0) req[b] = 1;
                end
                sack = (div != 0) && ($urandom_range(div - 1) == 0);
            end
        end
        req = '0; sack = 0; tick(3);

        // Saturation of the connection counter
        rst_n = 0; tick(1); rst_n = 1; tick(1);
        for (int i = 0; i < 260; i++) quick_session(4'b0001);
        chk("conn_saturate", conn, 255);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tcp_handshake_scheduler.md
Name: tcp_handshake_scheduler

Overview:
- Shares one server-side handshake endpoint among N_CLIENTS requesters using round-robin arbitration.
- Sequences the three-way handshake for the granted requester: SYN, wait for SYN_ACK, then ACK.
- Handles SYN_ACK timeout with bounded retries, holds the connection until the requester releases it, and counts completed connections.
- Sits between the per-client control lines and the server-side SYN/SYN_ACK/ACK wires in the TCP top level.

Parameters:
- N_CLIENTS, 4, number of requesters (2..16).
- TIMEOUT, 16, cycles to wait for SYN_ACK after each SYN (>=2).
- MAX_RETRY, 3, SYN re-sends allowed after the first before declaring failure (0..15).

Ports:
- clock, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- req, input, N_CLIENTS, per-client connection request, level; holding high keeps the connection.
- rcv_syn_ack, input, 1, SYN_ACK from server, single-cycle pulse.
- send_syn, output, 1, SYN to server, single-cycle pulse.
- send_ack, output, 1, ACK to server, single-cycle pulse.
- grant, output, N_CLIENTS, one-hot owner of the endpoint; all zero when idle.
- established, output, 1, high while in ESTABLISHED.
- fail, output, N_CLIENTS, one-cycle pulse on the owner's bit when retries are exhausted.
- busy, output, 1, state != IDLE.
- conn_count, output, 8, completed handshakes, saturates at 255.

Behaviour:
- All outputs are registered.
- Reset while rst=0, asynchronous, takes effect mid-handshake too:
  - state=IDLE; grant=0; send_syn=send_ack=established=busy=0; fail=0; conn_count=0.
  - Timer=0, retry=0, rr_ptr=N_CLIENTS-1, so client 0 has first priority.
- States: IDLE, SYN_SENT, ACK_SEND, ESTABLISHED.
- IDLE:
  - If any req bit is high, select the first set bit searching from rr_ptr+1 with wrap-around.
  - Next edge: grant=onehot(sel), send_syn=1 for one cycle, timer=0, retry=0, go to SYN_SENT.
  - Latency from req rising to send_syn high is 1 cycle.
- SYN_SENT:
  - timer increments each cycle.
  - rcv_syn_ack=1: go to ACK_SEND. This takes priority over timeout in the same cycle.
  - Timeout: timer==TIMEOUT-1 with no SYN_ACK.
    - If retry<MAX_RETRY: retry++, timer=0, pulse send_syn again, stay in SYN_SENT.
    - Otherwise: pulse fail on the owner bit, grant=0, rr_ptr=owner, go to IDLE.
  - Owner's req drops: abort to IDLE, no fail, rr_ptr=owner. Abort has priority over both SYN_ACK and timeout.
- ACK_SEND: one cycle. send_ack=1 on the following edge for exactly one cycle; conn_count+1 (saturating); go to ESTABLISHED.
- ESTABLISHED:
  - established=1 and grant held.
  - Stays until the owner's req drops, then on the next edge: grant=0, established=0, rr_ptr=owner, go to IDLE.
  - Re-arbitration can grant in the cycle after entering IDLE, so there is a 1-cycle idle gap minimum.
- rcv_syn_ack outside SYN_SENT is ignored.
- Changes to non-owner req bits never affect the current session.
- grant is always one-hot or zero.
- Timer width is clog2(TIMEOUT); retry width is 4 bits.

Test Plan:
- Basic handshake (N=4, TIMEOUT=16): req=0001, rcv_syn_ack 3 cycles after send_syn -> grant=0001, one send_syn, send_ack 2 cycles after rcv_syn_ack, established=1, conn_count=1. Drop req[0] -> grant=0 and established=0 next edge.
- Round-robin: req=1111, each session completes then its bit drops -> grant order 0001, 0010, 0100, 1000, 0001; conn_count=5.
- Timeout/retry (MAX_RETRY=3): no rcv_syn_ack -> send_syn pulses exactly 4 times, 16 cycles apart. fail=0001 for one cycle 16 cycles after the 4th SYN; then grant=0, conn_count unchanged.
- Late recovery: rcv_syn_ack in the same cycle as the 2nd timeout -> no 3rd SYN, send_ack follows, established=1.
- Abort and spurious input: owner req drops in SYN_SENT -> IDLE, fail=0, send_ack never asserted. A spurious rcv_syn_ack in IDLE produces no outputs.
- Reset mid-session: assert rst=0 asynchronously during ESTABLISHED -> all outputs 0 immediately (before the next edge). After release with req=0100, the first grant is 0100 and conn_count=1 after that handshake.
